// File: rtl/alu_issue_unit.sv
// Issue front end for a combinational RV32I ALU subset: accepts one instruction,
// reads operands from a 32x32 register file, drives the ALU and writes the result back.
module alu_issue_unit #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [4:0]      alu_fun,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    input  logic [XLEN-1:0] alu_res,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam logic [4:0] FN_ADD  = 5'd0;
    localparam logic [4:0] FN_SUB  = 5'd1;
    localparam logic [4:0] FN_SLL  = 5'd2;
    localparam logic [4:0] FN_XOR  = 5'd3;
    localparam logic [4:0] FN_OR   = 5'd4;
    localparam logic [4:0] FN_ADDI = 5'd5;
    localparam logic [4:0] FN_SLLI = 5'd6;
    localparam logic [4:0] FN_SLTI = 5'd7;
    localparam logic [4:0] FN_ORI  = 5'd8;
    localparam logic [4:0] FN_ANDI = 5'd9;
    localparam logic [4:0] FN_LUI  = 5'd10;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t state, state_next;

    logic [XLEN-1:0] rf [NREGS];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            dec_legal;
    logic            dec_is_r;
    logic            dec_is_lui;
    logic [4:0]      dec_fun;
    logic [XLEN-1:0] dec_imm;

    logic            op_legal;
    logic            op_is_r;
    logic            op_is_lui;
    logic [4:0]      op_rs1;
    logic [4:0]      op_rs2;
    logic [4:0]      op_rd;
    logic [XLEN-1:0] op_imm;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Decoding straight off the handshake lets alu_fun settle during DECODE,
    // a cycle ahead of the operands.
    always_comb begin
        dec_legal  = 1'b0;
        dec_is_r   = 1'b0;
        dec_is_lui = 1'b0;
        dec_fun    = FN_ADD;
        dec_imm    = {{(XLEN-12){instr[31]}}, instr[31:20]};
        case (opcode)
            OP_R: begin
                dec_is_r = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: begin dec_legal = 1'b1; dec_fun = FN_ADD; end
                    {7'b0100000, 3'b000}: begin dec_legal = 1'b1; dec_fun = FN_SUB; end
                    {7'b0000000, 3'b001}: begin dec_legal = 1'b1; dec_fun = FN_SLL; end
                    {7'b0000000, 3'b100}: begin dec_legal = 1'b1; dec_fun = FN_XOR; end
                    {7'b0000000, 3'b110}: begin dec_legal = 1'b1; dec_fun = FN_OR;  end
                    default: ;
                endcase
            end
            OP_I: begin
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_fun = FN_ADDI; end
                    3'b001: begin
                        dec_legal = (funct7 == 7'b0000000);
                        dec_fun   = FN_SLLI;
                        dec_imm   = XLEN'(instr[24:20]);
                    end
                    3'b010: begin dec_legal = 1'b1; dec_fun = FN_SLTI; end
                    3'b110: begin dec_legal = 1'b1; dec_fun = FN_ORI;  end
                    3'b111: begin dec_legal = 1'b1; dec_fun = FN_ANDI; end
                    default: ;
                endcase
            end
            OP_LUI: begin
                dec_legal  = 1'b1;
                dec_is_lui = 1'b1;
                dec_fun    = FN_LUI;
                dec_imm    = XLEN'({instr[31:12], 12'h000});
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = DECODE;
            end
            DECODE:  state_next = op_legal ? EXEC : IDLE;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_fun   <= FN_ADD;
            alu_in1   <= '0;
            alu_in2   <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            illegal   <= 1'b0;
            op_legal  <= 1'b0;
            op_is_r   <= 1'b0;
            op_is_lui <= 1'b0;
            op_rs1    <= '0;
            op_rs2    <= '0;
            op_rd     <= '0;
            op_imm    <= '0;
            for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            wb_valid <= (state == EXEC);
            illegal  <= (state == DECODE) && !op_legal;

            if (state == IDLE && instr_valid) begin
                op_legal  <= dec_legal;
                op_is_r   <= dec_is_r;
                op_is_lui <= dec_is_lui;
                op_rs1    <= instr[19:15];
                op_rs2    <= instr[24:20];
                op_rd     <= instr[11:7];
                op_imm    <= dec_imm;
                if (dec_legal) alu_fun <= dec_fun;
            end

            if (state == DECODE && op_legal) begin
                alu_in1 <= op_is_lui ? '0 : rf[op_rs1];
                alu_in2 <= op_is_r ? rf[op_rs2] : op_imm;
            end

            if (state == EXEC) begin
                wb_rd   <= op_rd;
                wb_data <= alu_res;
            end

            // Commit at the end of WB so a debug read of rd shows the old value during WB.
            if (state == WB && wb_rd != '0) rf[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU and instruction-level reference model,
// directed literal checks followed by randomized instruction traffic.
module tb_alu_issue_unit;

    localparam logic [4:0] FN_ADD  = 5'd0;
    localparam logic [4:0] FN_SUB  = 5'd1;
    localparam logic [4:0] FN_SLL  = 5'd2;
    localparam logic [4:0] FN_XOR  = 5'd3;
    localparam logic [4:0] FN_OR   = 5'd4;
    localparam logic [4:0] FN_ADDI = 5'd5;
    localparam logic [4:0] FN_SLLI = 5'd6;
    localparam logic [4:0] FN_SLTI = 5'd7;
    localparam logic [4:0] FN_ORI  = 5'd8;
    localparam logic [4:0] FN_ANDI = 5'd9;
    localparam logic [4:0] FN_LUI  = 5'd10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [4:0]  alu_fun;
    logic [31:0] alu_in1, alu_in2, alu_res;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_pass   = 0;

    alu_issue_unit #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_fun(alu_fun), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .alu_res(alu_res), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_fun)
            FN_ADD, FN_ADDI: alu_res = alu_in1 + alu_in2;
            FN_SUB:          alu_res = alu_in1 - alu_in2;
            FN_SLL, FN_SLLI: alu_res = alu_in1 << alu_in2[4:0];
            FN_XOR:          alu_res = alu_in1 ^ alu_in2;
            FN_OR, FN_ORI:   alu_res = alu_in1 | alu_in2;
            FN_ANDI:         alu_res = alu_in1 & alu_in2;
            FN_SLTI:         alu_res = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
            FN_LUI:          alu_res = alu_in2;
            default:         alu_res = 32'hDEADBEEF;
        endcase
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] mreg [32];
    int  cyc = 0;
    bit  model_ok = 0;
    int  ready_from = 0, wb_at = -1, ill_at = -1, commit_at = -1, legal_acc = -100, rst_at = -1;
    logic [4:0]  exp_fun, exp_rd;
    logic [31:0] exp_a, exp_b, exp_data;
    int  hs_count = 0;

    function automatic void model_exec(input logic [31:0] w, output bit legal, output logic [4:0] fun,
                                       output logic [31:0] a, output logic [31:0] b, output logic [31:0] res);
        logic [31:0] v1, v2, imm;
        logic [6:0]  f7;
        logic [2:0]  f3;
        v1 = mreg[w[19:15]];
        v2 = mreg[w[24:20]];
        imm = {{20{w[31]}}, w[31:20]};
        f7 = w[31:25];
        f3 = w[14:12];
        legal = 1; fun = FN_ADD; a = v1; b = imm; res = '0;
        if (w[6:0] == 7'b0110011) begin
            b = v2;
            if      (f7 == 7'h00 && f3 == 3'd0) begin fun = FN_ADD; res = v1 + v2; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin fun = FN_SUB; res = v1 - v2; end
            else if (f7 == 7'h00 && f3 == 3'd1) begin fun = FN_SLL; res = v1 << v2[4:0]; end
            else if (f7 == 7'h00 && f3 == 3'd4) begin fun = FN_XOR; res = v1 ^ v2; end
            else if (f7 == 7'h00 && f3 == 3'd6) begin fun = FN_OR;  res = v1 | v2; end
            else legal = 0;
        end else if (w[6:0] == 7'b0010011) begin
            case (f3)
                3'd0: begin fun = FN_ADDI; res = v1 + imm; end
                3'd1: begin
                    fun = FN_SLLI; b = {27'b0, w[24:20]}; res = v1 << w[24:20];
                    legal = (f7 == 7'h00);
                end
                3'd2: begin fun = FN_SLTI; res = ($signed(v1) < $signed(imm)) ? 32'd1 : 32'd0; end
                3'd6: begin fun = FN_ORI;  res = v1 | imm; end
                3'd7: begin fun = FN_ANDI; res = v1 & imm; end
                default: legal = 0;
            endcase
        end else if (w[6:0] == 7'b0110111) begin
            fun = FN_LUI; a = '0; b = {w[31:12], 12'h000}; res = b;
        end else begin
            legal = 0;
        end
    endfunction

    always @(posedge clk) begin
        bit lg;
        logic [4:0] f;
        logic [31:0] a, b, r;
        int n;
        cyc++;
        if (rst) begin
            for (int i = 0; i < 32; i++) mreg[i] = '0;
            model_ok = 1;
            ready_from = cyc; wb_at = -1; ill_at = -1; commit_at = -1; legal_acc = -100; rst_at = cyc;
        end else if (model_ok) begin
            if (commit_at == cyc - 1) begin
                if (exp_rd != 5'd0) mreg[exp_rd] = exp_data;
                commit_at = -1;
            end
            if (instr_valid && (cyc - 1) >= ready_from) begin
                n = cyc - 1;
                model_exec(instr, lg, f, a, b, r);
                if (lg) begin
                    legal_acc = n; exp_fun = f; exp_a = a; exp_b = b;
                    exp_rd = instr[11:7]; exp_data = r;
                    wb_at = n + 3; commit_at = n + 3; ready_from = n + 4;
                end else begin
                    ill_at = n + 2; ready_from = n + 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            if (instr_valid && instr_ready) hs_count++;
            chk("instr_ready", 32'(instr_ready), 32'(cyc >= ready_from));
            chk("wb_valid", 32'(wb_valid), 32'(cyc == wb_at));
            chk("illegal", 32'(illegal), 32'(cyc == ill_at));
            if (cyc == wb_at) begin
                chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
                chk("wb_data", wb_data, exp_data);
            end
            if (cyc > legal_acc && cyc <= legal_acc + 3) chk("alu_fun", 32'(alu_fun), 32'(exp_fun));
            if (cyc == legal_acc + 2) begin
                chk("alu_in1", alu_in1, exp_a);
                chk("alu_in2", alu_in2, exp_b);
            end
            if (cyc == rst_at) begin
                chk("rst_alu_fun", 32'(alu_fun), 32'(FN_ADD));
                chk("rst_alu_in1", alu_in1, 32'd0);
                chk("rst_alu_in2", alu_in2, 32'd0);
                chk("rst_wb_rd", 32'(wb_rd), 32'd0);
                chk("rst_wb_data", wb_data, 32'd0);
            end
            chk("dbg_data", dbg_data, mreg[dbg_addr]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] w);
        instr = w;
        instr_valid = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (instr_ready === 1'b1) break;
        end
        if (instr_ready !== 1'b1) chk("accept_timeout", 32'(instr_ready), 32'd1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = $urandom();
    endtask

    task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
        repeat (3) @(negedge clk);
        chk("lit_wb_valid", 32'(wb_valid), 32'd1);
        chk("lit_wb_rd", 32'(wb_rd), 32'(rd));
        chk("lit_wb_data", wb_data, data);
        @(posedge clk); #1;
    endtask

    task automatic peek(input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        @(negedge clk);
        chk("lit_dbg", dbg_data, exp);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [6:0]  f7;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        imm = 12'($urandom());
        f7  = ($urandom_range(0, 3) == 0) ? 7'($urandom()) : 7'h00;
        case ($urandom_range(0, 12))
            0:  return {7'h00, rs2, rs1, 3'd0, rd, 7'b0110011};
            1:  return {7'h20, rs2, rs1, 3'd0, rd, 7'b0110011};
            2:  return {7'h00, rs2, rs1, 3'd1, rd, 7'b0110011};
            3:  return {7'h00, rs2, rs1, 3'd4, rd, 7'b0110011};
            4:  return {7'h00, rs2, rs1, 3'd6, rd, 7'b0110011};
            5:  return {imm, rs1, 3'd0, rd, 7'b0010011};
            6:  return {f7, imm[4:0], rs1, 3'd1, rd, 7'b0010011};
            7:  return {imm, rs1, 3'd2, rd, 7'b0010011};
            8:  return {imm, rs1, 3'd6, rd, 7'b0010011};
            9:  return {imm, rs1, 3'd7, rd, 7'b0010011};
            10: return {20'($urandom()), rd, 7'b0110111};
            11: return {7'($urandom()), rs2, rs1, 3'($urandom()), rd, 7'b0110011};
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("lit_reset_ready", 32'(instr_ready), 32'd1);
        chk("lit_reset_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) peek(5'(i), 32'd0);

        send(32'h00500093); expect_wb(5'd1, 32'd5);
        send(32'h00300113); expect_wb(5'd2, 32'd3);
        send(32'h002081B3); expect_wb(5'd3, 32'd8);
        send(32'h40208233); expect_wb(5'd4, 32'd2);
        send(32'h123452B7); expect_wb(5'd5, 32'h12345000);
        peek(5'd5, 32'h12345000);
        send(32'hFFF0A313); expect_wb(5'd6, 32'd0);
        peek(5'd6, 32'd0);
        send(32'h00700013); expect_wb(5'd0, 32'd7);
        peek(5'd0, 32'd0);

        send(32'h00000000);
        repeat (2) @(negedge clk);
        chk("lit_illegal", 32'(illegal), 32'd1);
        chk("lit_illegal_no_wb", 32'(wb_valid), 32'd0);
        @(posedge clk); #1;
        peek(5'd1, 32'd5);
        peek(5'd3, 32'd8);

        // ADDI x8,x8,1 held valid for 20 cycles
        h0 = hs_count;
        instr = {12'd1, 5'd8, 3'd0, 5'd8, 7'b0010011};
        instr_valid = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        instr_valid = 1'b0;
        chk("lit_hold_accepts", 32'(hs_count - h0), 32'd5);
        repeat (4) begin @(posedge clk); #1; end
        peek(5'd8, 32'd5);

        send({12'd9, 5'd0, 3'd0, 5'd7, 7'b0010011});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("lit_rst_mid_ready", 32'(instr_ready), 32'd1);
        chk("lit_rst_mid_no_wb", 32'(wb_valid), 32'd0);
        @(posedge clk); #1;
        peek(5'd7, 32'd0);
        peek(5'd1, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            instr_valid = ($urandom_range(0, 3) != 0);
            instr = rand_instr();
            dbg_addr = 5'($urandom_range(0, 8));
            rst = ($urandom_range(0, 249) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        instr_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
